wt_accum_pipe: RTL

Parametrised, pipelined multi-operand adder with packet accumulation. Each beat carries NUM_OPS operands of WIDTH bits. Beats are reduced through a 3:2 carry-save (Wallace) tree into a carry-save accumulator. On the last beat of a packet, the accumulated pair is resolved by a final carry-propagate adder. It extends the team's fixed 4-operand Wallace adders to arbitrary operand count and width, signed/unsigned mode, multi-beat summation and valid/ready flow control.

---
 rtl/wt_accum_pipe.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/wt_accum_pipe.sv
// wt_accum_pipe: pipelined multi-operand adder with packet accumulation.
// Each accepted beat carries NUM_OPS operands of WIDTH bits. The operands are
// extended to RWIDTH, reduced with the carry-save accumulator through a 3:2
// (Wallace) tree, and the final pair is resolved by one carry-propagate adder
// when the packet's last beat arrives.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_in_valid/o_in_ready   input beat handshake
//   i_in_last               accepted beat closes the packet
//   i_mode_signed           1: sign-extend this beat's operands, 0: zero-extend
//   i_operands              operand i at [i*WIDTH +: WIDTH]
//   o_out_valid/i_out_ready result handshake
//   o_result                packet sum modulo 2^RWIDTH
//   o_out_beats             beats in the packet, saturating at 255
module wt_accum_pipe #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned NUM_OPS = 4,
    parameter int unsigned RWIDTH  = WIDTH + 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic                     i_in_last,
    input  logic                     i_mode_signed,
    input  logic [NUM_OPS*WIDTH-1:0] i_operands,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [RWIDTH-1:0]        o_result,
    output logic [7:0]               o_out_beats
);

    // Tree inputs: all operands plus the two accumulator rows.
    localparam int NROWS = NUM_OPS + 2;

    logic              w_stall;
    logic              w_accept;
    logic [RWIDTH-1:0] w_ext [NUM_OPS];
    logic [RWIDTH-1:0] w_sum;
    logic [RWIDTH-1:0] w_carry;
    logic [7:0]        w_cnt_inc;

    logic              r_s1_valid;
    logic              r_s1_last;
    logic [RWIDTH-1:0] r_s1_ops [NUM_OPS];
    logic [RWIDTH-1:0] r_acc_s;
    logic [RWIDTH-1:0] r_acc_c;
    logic [7:0]        r_cnt;
    logic              r_fin_valid;
    logic [RWIDTH-1:0] r_fin_s;
    logic [RWIDTH-1:0] r_fin_c;
    logic [7:0]        r_fin_beats;
    logic              r_out_valid;
    logic [RWIDTH-1:0] r_result;
    logic [7:0]        r_out_beats;

    // The whole pipeline freezes while a result waits to be consumed.
    assign w_stall     = r_out_valid && !i_out_ready;
    assign o_in_ready  = !w_stall;
    assign w_accept    = i_in_valid && o_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_out_beats = r_out_beats;

    always_comb begin
        for (int i = 0; i < int'(NUM_OPS); i++) begin
            w_ext[i] = {{(RWIDTH - WIDTH){i_mode_signed & i_operands[i*WIDTH + WIDTH - 1]}},
                        i_operands[i*WIDTH +: WIDTH]};
        end
    end

    // Level-by-level 3:2 reduction: each level compresses every full group of
    // three rows into a sum row and a left-shifted carry row, leftovers pass
    // through. Runs until two rows remain.
    always_comb begin
        logic [RWIDTH-1:0] rows     [NROWS];
        logic [RWIDTH-1:0] nxt_rows [NROWS];
        int                cnt;
        int                nxt;
        for (int k = 0; k < int'(NUM_OPS); k++) begin
            rows[k] = r_s1_ops[k];
        end
        rows[NUM_OPS]     = r_acc_s;
        rows[NUM_OPS + 1] = r_acc_c;
        nxt_rows          = rows;
        cnt               = NROWS;
        nxt               = 0;
        for (int lvl = 0; lvl < NROWS; lvl++) begin
            if (cnt > 2) begin
                nxt      = 0;
                nxt_rows = rows;
                for (int g = 0; g < NROWS / 3; g++) begin
                    if (3*g + 2 < cnt) begin
                        nxt_rows[nxt]     = rows[3*g] ^ rows[3*g + 1] ^ rows[3*g + 2];
                        nxt_rows[nxt + 1] = ((rows[3*g] & rows[3*g + 1]) |
                                             (rows[3*g] & rows[3*g + 2]) |
                                             (rows[3*g + 1] & rows[3*g + 2])) << 1;
                        nxt = nxt + 2;
                    end
                end
                for (int r = 0; r < NROWS; r++) begin
                    if (r >= (cnt / 3) * 3 && r < cnt) begin
                        nxt_rows[nxt] = rows[r];
                        nxt = nxt + 1;
                    end
                end
                rows = nxt_rows;
                cnt  = nxt;
            end
        end
        w_sum   = rows[0];
        w_carry = rows[1];
    end

    assign w_cnt_inc = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;

    // S1: extended operand capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            for (int i = 0; i < int'(NUM_OPS); i++) begin
                r_s1_ops[i] <= '0;
            end
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_ops  <= w_ext;
                r_s1_last <= i_in_last;
            end
        end
    end

    // S2: carry-save accumulate; last beat hands the pair to FIN and clears ACC
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc_s     <= '0;
            r_acc_c     <= '0;
            r_cnt       <= '0;
            r_fin_valid <= 1'b0;
            r_fin_s     <= '0;
            r_fin_c     <= '0;
            r_fin_beats <= '0;
        end else if (!w_stall) begin
            if (r_s1_valid && r_s1_last) begin
                r_fin_s     <= w_sum;
                r_fin_c     <= w_carry;
                r_fin_beats <= w_cnt_inc;
                r_fin_valid <= 1'b1;
                r_acc_s     <= '0;
                r_acc_c     <= '0;
                r_cnt       <= '0;
            end else begin
                r_fin_valid <= 1'b0;
                if (r_s1_valid) begin
                    r_acc_s <= w_sum;
                    r_acc_c <= w_carry;
                    r_cnt   <= w_cnt_inc;
                end
            end
        end
    end

    // S3: final carry-propagate add
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_out_beats <= '0;
        end else if (!w_stall) begin
            r_out_valid <= r_fin_valid;
            if (r_fin_valid) begin
                r_result    <= r_fin_s + r_fin_c;
                r_out_beats <= r_fin_beats;
            end
        end
    end

endmodule
